// File: rtl/unified_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Purpose:
//   Shares one single-port memory between the core's instruction-fetch and
//   data-access interfaces. Only one transaction is outstanding at a time.
//   Data wins arbitration by default. A starvation counter forces a fetch
//   grant after STARVE_LIMIT consecutive data grants that were made while a
//   fetch was waiting. A watchdog aborts a transfer that makes no progress.
//
// Handshake semantics (all interfaces):
//   - Core side: a request is a level (fetch: i_inst_rd_en != 0, data:
//     i_data_rd_en_ma | i_data_wr_en_ma). The requester holds it until its
//     one-cycle ready pulse (o_instr_ready / o_data_ready). Requests are only
//     sampled in IDLE. A request dropped after it was sampled still completes
//     and still pulses ready.
//   - Memory side: o_mem_req is held with stable o_mem_* until a cycle with
//     i_mem_gnt = 1. One response cycle (i_mem_rvalid = 1) follows at least one
//     cycle later. i_mem_gnt outside REQ and i_mem_rvalid outside WAIT are
//     ignored.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   i_inst_rd_en / i_inst_addr        fetch byte-lane mask (request) / address
//   o_instr_ready / o_instr_data      fetch done pulse / fetched word (held)
//   i_data_rd_en_ma / i_data_wr_en_ma data read / write request (write wins)
//   i_data_rd_en_ctrl                 data byte-lane mask
//   i_data_addr / i_data_wr           data address / write data
//   o_data_ready / o_data_rd          data done pulse / read data (held)
//   o_mem_req/we/be/addr/wdata        memory request bundle
//   i_mem_gnt                         memory accepted the request
//   i_mem_rvalid / i_mem_rdata        memory response / read data
//   o_busy                            arbiter not in IDLE
//   o_err_timeout                     sticky watchdog abort flag
//   o_dbg_state                       current FSM state (IDLE=0 REQ=1 WAIT=2 RESP=3)
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // fetch interface
  input  logic [DATA_WIDTH/8-1:0] i_inst_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_inst_addr,
  output logic                    o_instr_ready,
  output logic [DATA_WIDTH-1:0]   o_instr_data,
  // data interface
  input  logic                    i_data_rd_en_ma,
  input  logic                    i_data_wr_en_ma,
  input  logic [DATA_WIDTH/8-1:0] i_data_rd_en_ctrl,
  input  logic [ADDR_WIDTH-1:0]   i_data_addr,
  input  logic [DATA_WIDTH-1:0]   i_data_wr,
  output logic                    o_data_ready,
  output logic [DATA_WIDTH-1:0]   o_data_rd,
  // memory interface
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic                    i_mem_gnt,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  // status
  output logic                    o_busy,
  output logic                    o_err_timeout,
  output logic [1:0]              o_dbg_state
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  // Watchdog disabled entirely when TIMEOUT_CYCLES == 0.
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam int WDOG_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX =
    WDOG_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Transaction registers; owner_q = 1 means the data port owns the transfer.
  logic                  owner_q,      owner_d;
  logic                  we_q,         we_d;
  logic [BE_W-1:0]       be_q,         be_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
  logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
  logic [DATA_WIDTH-1:0] data_rd_q,    data_rd_d;
  logic [STARVE_W-1:0]   starve_q,     starve_d;
  logic [WDOG_W-1:0]     wdog_q,       wdog_d;
  logic                  err_q,        err_d;

  logic fetch_pend;
  logic data_pend;
  logic grant_data;
  logic grant_fetch;
  logic timeout_hit;

  // ---------------------------------------------------------------------------
  // Arbitration and watchdog decode
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pend  = |i_inst_rd_en;
    data_pend   = i_data_rd_en_ma | i_data_wr_en_ma;
    // Data wins unless a waiting fetch has been passed over STARVE_LIMIT times.
    grant_data  = data_pend && !(fetch_pend && (starve_q == STARVE_MAX));
    grant_fetch = fetch_pend && !grant_data;
    // Abort only when the expected progress event did not arrive this cycle.
    timeout_hit = WDOG_EN && (wdog_q == WDOG_MAX) &&
                  (((state_q == ST_REQ)  && !i_mem_gnt) ||
                   ((state_q == ST_WAIT) && !i_mem_rvalid));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_data || grant_fetch) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_mem_gnt) begin
          state_d = ST_WAIT;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (i_mem_rvalid || timeout_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_mem_req     = (state_q == ST_REQ);
    o_busy        = (state_q != ST_IDLE);
    o_instr_ready = (state_q == ST_RESP) && !owner_q;
    o_data_ready  = (state_q == ST_RESP) &&  owner_q;
    o_dbg_state   = state_q;
  end

  assign o_mem_we      = we_q;
  assign o_mem_be      = be_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wdata   = wdata_q;
  assign o_instr_data  = instr_data_q;
  assign o_data_rd     = data_rd_q;
  assign o_err_timeout = err_q;

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d      = owner_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    instr_data_d = instr_data_q;
    data_rd_d    = data_rd_q;
    starve_d     = starve_q;
    wdog_d       = wdog_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          owner_d = 1'b1;
          we_d    = i_data_wr_en_ma;
          be_d    = i_data_rd_en_ctrl;
          addr_d  = i_data_addr;
          wdata_d = i_data_wr;
          // Count only grants that overtook a waiting fetch.
          if (fetch_pend && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
          end
          wdog_d = '0;
        end else if (grant_fetch) begin
          owner_d  = 1'b0;
          we_d     = 1'b0;
          be_d     = i_inst_rd_en;
          addr_d   = i_inst_addr;
          wdata_d  = '0;
          starve_d = '0;
          wdog_d   = '0;
        end
      end
      ST_REQ, ST_WAIT: begin
        // Counter spans REQ and WAIT together; it saturates so a late grant
        // cannot wrap it and extend the budget.
        if (WDOG_EN && (wdog_q != WDOG_MAX)) begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
        if ((state_q == ST_WAIT) && i_mem_rvalid) begin
          if (owner_q) begin
            data_rd_d = i_mem_rdata;
          end else begin
            instr_data_d = i_mem_rdata;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
          if (owner_q) begin
            data_rd_d = '0;
          end else begin
            instr_data_d = '0;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      instr_data_q <= '0;
      data_rd_q    <= '0;
      starve_q     <= '0;
      wdog_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      instr_data_q <= instr_data_d;
      data_rd_q    <= data_rd_d;
      starve_q     <= starve_d;
      wdog_q       <= wdog_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

  localparam int STARVE_LIMIT   = 4;
  localparam int TIMEOUT_CYCLES = 256;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  i_inst_rd_en;
  logic [31:0] i_inst_addr;
  logic        o_instr_ready;
  logic [31:0] o_instr_data;
  logic        i_data_rd_en_ma;
  logic        i_data_wr_en_ma;
  logic [3:0]  i_data_rd_en_ctrl;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wr;
  logic        o_data_ready;
  logic [31:0] o_data_rd;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy;
  logic        o_err_timeout;
  logic [1:0]  o_dbg_state;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_inst_rd_en(i_inst_rd_en), .i_inst_addr(i_inst_addr),
    .o_instr_ready(o_instr_ready), .o_instr_data(o_instr_data),
    .i_data_rd_en_ma(i_data_rd_en_ma), .i_data_wr_en_ma(i_data_wr_en_ma),
    .i_data_rd_en_ctrl(i_data_rd_en_ctrl), .i_data_addr(i_data_addr),
    .i_data_wr(i_data_wr), .o_data_ready(o_data_ready), .o_data_rd(o_data_rd),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_err_timeout(o_err_timeout), .o_dbg_state(o_dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Transactions, queues, counters
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t stage_f[$];
  txn_t stage_d[$];
  txn_t fetch_q[$];
  txn_t data_q[$];

  logic [68:0] exp_mem_q[$];   // {we, be, addr, wdata}
  logic [33:0] exp_rsp_q[$];   // {owner(1=data), check_data, data}

  int checks = 0;
  int errors = 0;
  int m_starve = 0;
  int ready_cnt = 0;
  int last_req_cycles = 0;

  logic [31:0] dmem [logic [31:0]];  // memory seen by the DUT
  logic [31:0] mmem [logic [31:0]];  // reference model memory

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] d_read(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : init_word(a);
  endfunction

  function automatic txn_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  // Reference model: service order follows the arbitration rules applied to
  // two requester queues that always present their head entry.
  function automatic void plan_round();
    txn_t fq[$];
    txn_t dq[$];
    txn_t t;
    logic own;
    fq = stage_f;
    dq = stage_d;
    while (fq.size() > 0 || dq.size() > 0) begin
      if (fq.size() > 0 && (dq.size() == 0 || m_starve >= STARVE_LIMIT)) begin
        t = fq.pop_front(); own = 1'b0; m_starve = 0;
      end else begin
        t = dq.pop_front(); own = 1'b1;
        if (fq.size() > 0) m_starve++;
      end
      exp_mem_q.push_back(t);
      if (t.we) begin
        mmem[t.addr] = merge(m_read(t.addr), t.wdata, t.be);
        exp_rsp_q.push_back({own, 1'b0, 32'h0});
      end else begin
        exp_rsp_q.push_back({own, 1'b1, m_read(t.addr)});
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Memory responder
  // ---------------------------------------------------------------------------
  bit rand_dly = 0;
  bit no_gnt = 0;
  bit hold_rv = 0;
  bit force_rv = 0;
  int gnt_dly_fix = 0;
  int rsp_phase = 0;
  int rsp_cnt = 0;
  txn_t rsp_t;

  initial begin : mem_responder
    i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
    forever begin
      @(negedge clk);
      i_mem_gnt = 0; i_mem_rvalid = 0;
      if (!rst_n) begin
        rsp_phase = 0;
      end else if (force_rv) begin
        i_mem_rvalid = 1; i_mem_rdata = 32'hBAD0_BAD0; force_rv = 0;
      end else begin
        case (rsp_phase)
          0: begin
            if (o_mem_req && !no_gnt) begin
              rsp_t = mk(o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata);
              rsp_cnt = rand_dly ? $urandom_range(0, 3) : gnt_dly_fix;
              if (rsp_cnt == 0) begin
                i_mem_gnt = 1; rsp_phase = 2;
                rsp_cnt = rand_dly ? $urandom_range(0, 2) : 0;
              end else rsp_phase = 1;
            end else if (rand_dly && !o_mem_req && $urandom_range(0, 7) == 0) begin
              // stray handshakes outside REQ/WAIT
              i_mem_gnt = 1; i_mem_rvalid = 1; i_mem_rdata = $urandom;
            end
          end
          1: begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
              i_mem_gnt = 1; rsp_phase = 2;
              rsp_cnt = rand_dly ? $urandom_range(0, 2) : 0;
            end
          end
          default: begin
            if (!hold_rv) begin
              if (rsp_cnt == 0) begin
                i_mem_rvalid = 1; rsp_phase = 0;
                if (rsp_t.we) begin
                  dmem[rsp_t.addr] = merge(d_read(rsp_t.addr), rsp_t.wdata, rsp_t.be);
                  i_mem_rdata = $urandom;
                end else begin
                  i_mem_rdata = d_read(rsp_t.addr);
                end
              end else rsp_cnt--;
            end
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Requester drivers
  // ---------------------------------------------------------------------------
  initial begin : fetch_driver
    i_inst_rd_en = 0; i_inst_addr = 0;
    forever begin
      @(negedge clk);
      if (o_instr_ready && fetch_q.size() > 0) void'(fetch_q.pop_front());
      if (fetch_q.size() > 0) begin
        i_inst_rd_en = fetch_q[0].be; i_inst_addr = fetch_q[0].addr;
      end else begin
        i_inst_rd_en = 0; i_inst_addr = $urandom;
      end
    end
  end

  initial begin : data_driver
    i_data_rd_en_ma = 0; i_data_wr_en_ma = 0; i_data_rd_en_ctrl = 0;
    i_data_addr = 0; i_data_wr = 0;
    forever begin
      @(negedge clk);
      if (o_data_ready && data_q.size() > 0) void'(data_q.pop_front());
      if (data_q.size() > 0) begin
        i_data_wr_en_ma   = data_q[0].we;
        i_data_rd_en_ma   = data_q[0].we ? 1'($urandom_range(0, 1)) : 1'b1;
        i_data_rd_en_ctrl = data_q[0].be;
        i_data_addr       = data_q[0].addr;
        i_data_wr         = data_q[0].wdata;
      end else begin
        i_data_wr_en_ma = 0; i_data_rd_en_ma = 0;
        i_data_rd_en_ctrl = 4'($urandom); i_data_addr = $urandom; i_data_wr = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitors
  // ---------------------------------------------------------------------------
  bit req_prev = 0;
  int req_cycles = 0;
  logic [68:0] req_lat;

  initial begin : mem_monitor
    logic [68:0] e;
    logic [68:0] cur;
    forever begin
      @(negedge clk);
      cur = {o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata};
      if (o_mem_req && !req_prev) begin
        req_lat = cur; req_cycles = 1;
        if (exp_mem_q.size() == 0) fail_event("mem_req_unexpected");
        else begin
          e = exp_mem_q.pop_front();
          if (!e[68]) begin e[31:0] = 0; cur[31:0] = 0; end
          check("mem_req_fields", cur, e);
        end
      end else if (o_mem_req) begin
        req_cycles++;
        check("mem_req_stable", cur, req_lat);
      end else if (req_prev) begin
        last_req_cycles = req_cycles;
      end
      req_prev = o_mem_req;
    end
  end

  logic [31:0] hold_instr = 0;
  logic [31:0] hold_data = 0;
  bit data_known = 1;

  initial begin : rsp_monitor
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (o_instr_ready || o_data_ready) ready_cnt++;
      if (o_instr_ready && o_data_ready) fail_event("both_ready");
      else if (o_instr_ready || o_data_ready) begin
        if (exp_rsp_q.size() == 0) fail_event("ready_unexpected");
        else begin
          e = exp_rsp_q.pop_front();
          check("rsp_owner", o_data_ready, e[33]);
          if (e[33]) begin
            if (e[32]) check("rsp_data_rd", o_data_rd, e[31:0]);
            check("instr_data_hold", o_instr_data, hold_instr);
            hold_data = e[31:0]; data_known = e[32];
          end else begin
            check("rsp_instr_data", o_instr_data, e[31:0]);
            if (data_known) check("data_rd_hold", o_data_rd, hold_data);
            hold_instr = e[31:0];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round runner: loads both requesters together, waits for completion.
  // lat = negedges from first presented cycle to the first ready pulse.
  // ---------------------------------------------------------------------------
  task automatic run_round(input bit plan, output int lat);
    int n;
    if (plan) plan_round();
    @(posedge clk); #1;
    fetch_q = stage_f; data_q = stage_d;
    stage_f.delete(); stage_d.delete();
    lat = -1; n = 0;
    while ((exp_rsp_q.size() > 0 || o_busy || fetch_q.size() > 0 || data_q.size() > 0)
           && n < 3000) begin
      @(negedge clk);
      if (lat < 0 && (o_instr_ready || o_data_ready)) lat = n;
      n++;
    end
    if (n >= 3000) begin
      fail_event("round_timeout");
      exp_rsp_q.delete(); fetch_q.delete(); data_q.delete();
    end
    check("mem_q_drained", exp_mem_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  initial begin : main
    int lat;
    int n;
    int snap;
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_mem_outputs", {o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata}, 0);
    check("rst_core_outputs", {o_instr_ready, o_data_ready, o_instr_data, o_data_rd}, 0);
    check("rst_status", {o_busy, o_err_timeout, o_dbg_state}, 0);
    rst_n = 1;

    // Minimum-latency fetch
    dmem[32'h100] = 32'h0050_0093; mmem[32'h100] = 32'h0050_0093;
    stage_f.push_back(mk(1'b0, 4'hF, 32'h100, 32'h0));
    run_round(1'b1, lat);
    check("fetch_latency", lat, 3);
    check("fetch_word", o_instr_data, 32'h0050_0093);

    // Fetch and read in the same cycle: data first
    stage_f.push_back(mk(1'b0, 4'hF, 32'h108, 32'h0));
    stage_d.push_back(mk(1'b0, 4'hF, 32'h2004, 32'h0));
    run_round(1'b1, lat);
    check("read_first_latency", lat, 3);

    // Starvation: fetch held while data is back-to-back
    stage_f.push_back(mk(1'b0, 4'h3, 32'h10C, 32'h0));
    for (int i = 0; i < 6; i++) stage_d.push_back(mk(1'b0, 4'hF, 32'h2010 + 4 * i, 32'h0));
    run_round(1'b1, lat);

    // Partial write with delayed grant, then read back
    gnt_dly_fix = 3;
    stage_d.push_back(mk(1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF));
    stage_d.push_back(mk(1'b0, 4'hF, 32'h2000, 32'h0));
    run_round(1'b1, lat);
    check("req_cycles_gnt_delay3", last_req_cycles, 4);
    check("readback_merged", o_data_rd, {init_word(32'h2000) >> 16, 16'hBEEF});
    gnt_dly_fix = 0;
    check("err_clear_before_timeout", o_err_timeout, 0);

    // Watchdog: never granted
    no_gnt = 1;
    stage_d.push_back(mk(1'b0, 4'hF, 32'h3000, 32'h0));
    exp_mem_q.push_back(mk(1'b0, 4'hF, 32'h3000, 32'h0));
    exp_rsp_q.push_back({1'b1, 1'b1, 32'h0});
    run_round(1'b0, lat);
    no_gnt = 0;
    check("timeout_latency", lat, TIMEOUT_CYCLES + 1);
    check("timeout_req_cycles", last_req_cycles, TIMEOUT_CYCLES);
    check("timeout_err_set", o_err_timeout, 1);
    stage_f.push_back(mk(1'b0, 4'hF, 32'h104, 32'h0));
    run_round(1'b1, lat);
    check("timeout_err_sticky", o_err_timeout, 1);

    // Reset during WAIT, late rvalid afterwards
    hold_rv = 1;
    exp_mem_q.push_back(mk(1'b0, 4'hF, 32'h400, 32'h0));
    @(posedge clk); #1;
    fetch_q.push_back(mk(1'b0, 4'hF, 32'h400, 32'h0));
    n = 0;
    while (rsp_phase != 2 && n < 50) begin @(negedge clk); n++; end
    check("reset_test_granted", n < 50, 1);
    @(negedge clk);
    check("in_wait_state", {o_dbg_state, o_busy, o_mem_req}, {2'd2, 1'b1, 1'b0});
    rst_n = 0; fetch_q.delete();
    repeat (2) @(negedge clk);
    check("midrst_outputs", {o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_instr_ready,
                             o_data_ready, o_instr_data, o_data_rd}, 0);
    check("midrst_status", {o_busy, o_err_timeout, o_dbg_state}, 0);
    hold_rv = 0; m_starve = 0;
    hold_instr = 0; hold_data = 0; data_known = 1;
    rst_n = 1;
    snap = ready_cnt;
    force_rv = 1;
    repeat (6) @(negedge clk);
    check("late_rvalid_no_ready", ready_cnt - snap, 0);
    check("late_rvalid_idle", o_busy, 0);
    stage_f.push_back(mk(1'b0, 4'hF, 32'h100, 32'h0));
    run_round(1'b1, lat);
    check("post_reset_fetch_latency", lat, 3);

    // Randomized rounds
    rand_dly = 1;
    for (int r = 0; r < 30; r++) begin
      int nf;
      int nd;
      nf = $urandom_range(0, 3);
      nd = $urandom_range(0, 6);
      if (nf + nd == 0) nd = 1;
      for (int i = 0; i < nf; i++)
        stage_f.push_back(mk(1'b0, 4'($urandom_range(1, 15)),
                             32'h100 + 4 * $urandom_range(0, 15), 32'h0));
      for (int i = 0; i < nd; i++)
        stage_d.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                             32'h2000 + 4 * $urandom_range(0, 15), $urandom));
      run_round(1'b1, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
